// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an async FIFO: pointer, empty flag, output register.
// Optional occupancy outputs rlevel/raempty are built when FIFO_RD_LEVEL_EN is defined.
module fifo_read_ctrl #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [ADDRSIZE:0] AE_LVL = AEMPTY_LEVEL[ADDRSIZE:0];

    // A threshold beyond the pointer range could never be compared correctly.
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > (1 << ADDRSIZE)) begin : g_bad_level
        $error("AEMPTY_LEVEL out of range");
    end

    state_t              state_q;
    state_t              state_d;
    logic [ADDRSIZE:0]   rbin;
    logic [ADDRSIZE:0]   rbin_next;
    logic [ADDRSIZE:0]   rgray_next;
    logic                rinc;

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    assign raddr      = rbin[ADDRSIZE-1:0];
    assign dout_valid = (state_q == HOLD);

    // Fetch when memory has a word and the output register is free or being drained.
    always_comb begin
        rinc       = !rempty && ((state_q == IDLE) || dout_ready);
        rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rinc};
        rgray_next = bin2gray(rbin_next);
    end

    // Output-stage next state: a consume without a refill empties the register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rinc) state_d = HOLD;
            HOLD: if (dout_ready && !rinc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge rclk) begin
        if (rrst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Pointer, empty flag and output data; empty compares the full Gray word
    // so the wrap bit distinguishes full-lap from empty.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            dout   <= '0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            rempty <= (rgray_next == rq2_wptr);
            if (rinc) dout <= rdata;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDRSIZE:0] rlevel_next;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Words still in memory after this edge's fetch; the held dout word is excluded.
    always_comb begin
        rlevel_next = gray2bin(rq2_wptr) - rbin_next;
    end

    // Registered occupancy and almost-empty flag.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel  <= '0;
            raempty <= 1'b1;
        end else begin
            rlevel  <= rlevel_next;
            raempty <= (rlevel_next <= AE_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a memory model and data scoreboard.
// Define FIFO_RD_LEVEL_EN to also exercise rlevel/raempty.
module tb_fifo_read_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] rlevel;
    logic       raempty;
`endif

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] sb [$];
    int checks = 0;
    int errors = 0;

    fifo_read_ctrl dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rq2_wptr   (rq2_wptr),
        .rdata      (rdata),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel     (rlevel),
        .raempty    (raempty)
`endif
    );

    always #5 rclk = ~rclk;

    assign rdata = mem[raddr];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        wbin = wbin + 5'd1;
        rq2_wptr = gray(wbin);
        sb.push_back(d);
    endtask

    // Score any handshake on the coming edge, then advance one cycle.
    task automatic step();
        logic [7:0] e;
        if (dout_valid && dout_ready && !rrst) begin
            if (sb.size() == 0) begin
                check("extra_word", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("dout_data", {24'd0, dout}, {24'd0, e});
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        step();
        step();
        wbin = '0;
        rq2_wptr = '0;
        sb.delete();
        rrst = 1'b0;
    endtask

    initial begin
        logic seen_wrap;
        logic [3:0] prev_addr;
        rrst = 1'b1;
        rq2_wptr = '0;
        dout_ready = 1'b0;
        wbin = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        do_reset();
        check("rst_rptr", {27'd0, rptr}, 32'd0);
        check("rst_rempty", {31'd0, rempty}, 32'd1);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_raddr", {28'd0, raddr}, 32'd0);

        // Single word: two-cycle latency
        dout_ready = 1'b1;
        write_word(8'hA5);
        step();
        check("sw_rempty0", {31'd0, rempty}, 32'd0);
        check("sw_valid0", {31'd0, dout_valid}, 32'd0);
        step();
        check("sw_valid1", {31'd0, dout_valid}, 32'd1);
        check("sw_dout", {24'd0, dout}, 32'hA5);
        check("sw_rempty1", {31'd0, rempty}, 32'd1);
        check("sw_rptr", {27'd0, rptr}, 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("sw_idle", {31'd0, dout_valid}, 32'd0);
        check("sw_no_underflow", {28'd0, raddr}, 32'd1);
        check("sw_sb_empty", sb.size(), 32'd0);

        // Backpressure
        do_reset();
        dout_ready = 1'b0;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_dout", {24'd0, dout}, 32'h11);
            check("bp_raddr", {28'd0, raddr}, 32'd1);
            check("bp_valid", {31'd0, dout_valid}, 32'd1);
            step();
        end
        dout_ready = 1'b1;
        step();
        check("bp_dout22", {24'd0, dout}, 32'h22);
        step();
        check("bp_dout33", {24'd0, dout}, 32'h33);
        step();
        check("bp_done", {31'd0, dout_valid}, 32'd0);
        check("bp_sb_empty", sb.size(), 32'd0);

        // Wrap-around streaming of 20 words
        do_reset();
        dout_ready = 1'b1;
        seen_wrap = 1'b0;
        prev_addr = raddr;
        for (int i = 0; i < 20; i++) begin
            write_word(8'h40 + 8'(i));
            step();
            if (prev_addr == 4'd15 && raddr == 4'd0) seen_wrap = 1'b1;
            prev_addr = raddr;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (prev_addr == 4'd15 && raddr == 4'd0) seen_wrap = 1'b1;
            prev_addr = raddr;
        end
        check("wr_wrap_seen", {31'd0, seen_wrap}, 32'd1);
        check("wr_raddr", {28'd0, raddr}, 32'd4);
        check("wr_rptr", {27'd0, rptr}, 32'b11110);
        check("wr_rempty", {31'd0, rempty}, 32'd1);
        check("wr_valid", {31'd0, dout_valid}, 32'd0);
        check("wr_sb_empty", sb.size(), 32'd0);

        // Reset mid-stream
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'h70 + 8'(i));
        step();
        step();
        check("mr_valid_pre", {31'd0, dout_valid}, 32'd1);
        rrst = 1'b1;
        step();
        check("mr_valid", {31'd0, dout_valid}, 32'd0);
        check("mr_rempty", {31'd0, rempty}, 32'd1);
        check("mr_raddr", {28'd0, raddr}, 32'd0);
        check("mr_rptr", {27'd0, rptr}, 32'd0);
        check("mr_dout", {24'd0, dout}, 32'd0);
        step();
        check("mr_hold", {31'd0, dout_valid}, 32'd0);

`ifdef FIFO_RD_LEVEL_EN
        // Occupancy and almost-empty
        do_reset();
        check("lv_rst_level", {27'd0, rlevel}, 32'd0);
        check("lv_rst_aempty", {31'd0, raempty}, 32'd1);
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'h90 + 8'(i));
        step();
        check("lv_level5", {27'd0, rlevel}, 32'd5);
        step();
        check("lv_level4", {27'd0, rlevel}, 32'd4);
        check("lv_aempty4", {31'd0, raempty}, 32'd0);
        dout_ready = 1'b1;
        step();
        check("lv_level3", {27'd0, rlevel}, 32'd3);
        check("lv_aempty3", {31'd0, raempty}, 32'd0);
        step();
        check("lv_level2", {27'd0, rlevel}, 32'd2);
        check("lv_aempty2", {31'd0, raempty}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("lv_level0", {27'd0, rlevel}, 32'd0);
        check("lv_sb_empty", sb.size(), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, read data width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, memory address width; depth = 2^ADDRSIZE = 16.
REQ-003 SHALL have parameter AEMPTY_LEVEL, default 2, almost-empty threshold in words (used only under REQ-029).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 rclk  input  1  read-domain clock; all state updates on rising edge.
REQ-006 rrst  input  1  synchronous active-high reset.
REQ-007 rq2_wptr  input  ADDRSIZE+1  write pointer, Gray-coded, already synchronized into rclk.
REQ-008 rdata  input  DATASIZE  memory read data, combinational from raddr.
REQ-009 raddr  output  ADDRSIZE  memory read address.
REQ-010 rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to write domain.
REQ-011 rempty  output  1  registered; 1 = no unread word in memory.
REQ-012 dout  output  DATASIZE  registered output data.
REQ-013 dout_valid  output  1  dout holds a word not yet consumed.
REQ-014 dout_ready  input  1  consumer accepts dout when dout_valid=1 on the same edge.

Function
REQ-015 SHALL keep binary pointer rbin (ADDRSIZE+1 bits); raddr = rbin[ADDRSIZE-1:0]; rptr = registered (rbin>>1)^rbin.
REQ-016 Fetch condition rinc = !rempty && (!dout_valid || dout_ready).
REQ-017 On rinc: dout <= rdata, dout_valid <= 1, rbin <= rbin+1 (modulo 2^(ADDRSIZE+1)).
REQ-018 On dout_valid && dout_ready && !rinc: dout_valid <= 0; dout holds its last value.
REQ-019 On dout_valid && dout_ready && rinc (same edge): dout takes next word, dout_valid stays 1; sustained throughput 1 word/cycle.
REQ-020 While dout_valid=1 and dout_ready=0: dout, dout_valid, rbin, raddr SHALL stay unchanged.
REQ-021 rempty <= (gray(rbin_next) == rq2_wptr), all ADDRSIZE+1 bits compared, where rbin_next = rbin + rinc.
REQ-022 Latency: rq2_wptr change -> rempty=0 on next edge -> dout_valid=1 on the following edge (2 rclk).
REQ-023 Wrap-around: raddr 15 -> 0 with rbin MSB toggle; empty detection SHALL stay correct across the wrap.
REQ-024 Output stage states: IDLE (dout_valid=0) and HOLD (dout_valid=1); IDLE->HOLD on rinc; HOLD->IDLE on consume without rinc; HOLD->HOLD otherwise.
REQ-025 SHALL never advance rbin while rempty=1 (no underflow), regardless of dout_ready.

Reset
REQ-026 With rrst=1 at a rising edge: rbin=0, rptr=0, rempty=1, dout=0, dout_valid=0, state IDLE.
REQ-027 Reset mid-operation SHALL discard any word held in dout; no output changes until rrst deasserts.
REQ-028 First fetch after reset SHALL read address 0.

Configuration
REQ-029 Macro FIFO_RD_LEVEL_EN defined: SHALL add outputs rlevel (ADDRSIZE+1, registered occupancy = gray2bin(rq2_wptr) - rbin_next, modulo 2^(ADDRSIZE+1); excludes word held in dout) and raempty (registered, 1 when rlevel <= AEMPTY_LEVEL); both reset to 0 and 1 respectively.
REQ-030 FIFO_RD_LEVEL_EN undefined: rlevel and raempty ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset: rrst=1 for 2 cycles, rq2_wptr=0 -> rptr=0, rempty=1, dout_valid=0, dout=0.
REQ-032 Single word: memory[0]=8'hA5, rq2_wptr 0->1 (Gray 5'b00001), dout_ready=1 -> rempty=0 after 1 edge, dout=8'hA5 with dout_valid=1 after 2 edges, then rempty=1, rptr=5'b00001.
REQ-033 Backpressure: 3 words (11,22,33) available, dout_ready=0 for 5 cycles -> dout=11 stable, raddr=1; release -> 22,33 on consecutive cycles, then dout_valid=0.
REQ-034 Wrap: 20 words streamed, dout_ready=1 -> outputs in order, raddr goes 15->0, rbin=20, rptr=Gray(20)=5'b11110, rempty=1 at end, no extra word.
REQ-035 Reset mid-stream: rrst=1 while dout_valid=1 with 4 words pending -> dout_valid=0, rbin=0, rempty=1 next edge.
REQ-036 With FIFO_RD_LEVEL_EN, AEMPTY_LEVEL=2: rq2_wptr=Gray(5), nothing consumed yet -> rlevel steps to 4 after first fetch, raempty=0; drain to rlevel=2 -> raempty=1.
